// File: rtl/tl_ul_arbiter_2to1.sv
// Two-master to one-slave TileLink-UL arbiter: round-robin A channel with burst locking,
// D channel routed by the prepended source MSB. Define TLARB_FIXED_PRIO_EN for fixed priority (master 0).
module tl_ul_arbiter_2to1 #(
    parameter int SOURCE_W = 3,
    parameter int SIZE_W   = 3,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,

    input  logic                  m0_a_valid,
    output logic                  m0_a_ready,
    input  logic [2:0]            m0_a_opcode,
    input  logic [2:0]            m0_a_param,
    input  logic [SIZE_W-1:0]     m0_a_size,
    input  logic [SOURCE_W-1:0]   m0_a_source,
    input  logic [ADDR_W-1:0]     m0_a_address,
    input  logic [DATA_W/8-1:0]   m0_a_mask,
    input  logic [DATA_W-1:0]     m0_a_data,
    input  logic                  m0_a_corrupt,
    output logic                  m0_d_valid,
    input  logic                  m0_d_ready,
    output logic [2:0]            m0_d_opcode,
    output logic [1:0]            m0_d_param,
    output logic [SIZE_W-1:0]     m0_d_size,
    output logic [SOURCE_W-1:0]   m0_d_source,
    output logic [DATA_W-1:0]     m0_d_data,
    output logic                  m0_d_denied,
    output logic                  m0_d_corrupt,

    input  logic                  m1_a_valid,
    output logic                  m1_a_ready,
    input  logic [2:0]            m1_a_opcode,
    input  logic [2:0]            m1_a_param,
    input  logic [SIZE_W-1:0]     m1_a_size,
    input  logic [SOURCE_W-1:0]   m1_a_source,
    input  logic [ADDR_W-1:0]     m1_a_address,
    input  logic [DATA_W/8-1:0]   m1_a_mask,
    input  logic [DATA_W-1:0]     m1_a_data,
    input  logic                  m1_a_corrupt,
    output logic                  m1_d_valid,
    input  logic                  m1_d_ready,
    output logic [2:0]            m1_d_opcode,
    output logic [1:0]            m1_d_param,
    output logic [SIZE_W-1:0]     m1_d_size,
    output logic [SOURCE_W-1:0]   m1_d_source,
    output logic [DATA_W-1:0]     m1_d_data,
    output logic                  m1_d_denied,
    output logic                  m1_d_corrupt,

    output logic                  s_a_valid,
    input  logic                  s_a_ready,
    output logic [2:0]            s_a_opcode,
    output logic [2:0]            s_a_param,
    output logic [SIZE_W-1:0]     s_a_size,
    output logic [SOURCE_W:0]     s_a_source,
    output logic [ADDR_W-1:0]     s_a_address,
    output logic [DATA_W/8-1:0]   s_a_mask,
    output logic [DATA_W-1:0]     s_a_data,
    output logic                  s_a_corrupt,
    input  logic                  s_d_valid,
    output logic                  s_d_ready,
    input  logic [2:0]            s_d_opcode,
    input  logic [1:0]            s_d_param,
    input  logic [SIZE_W-1:0]     s_d_size,
    input  logic [SOURCE_W:0]     s_d_source,
    input  logic [DATA_W-1:0]     s_d_data,
    input  logic                  s_d_denied,
    input  logic                  s_d_corrupt,

    output logic                  dbg_a_state,
    output logic                  dbg_msg_done
);

    localparam int LANE_LOG2 = $clog2(DATA_W / 8);
    localparam int CNT_W     = 2 ** SIZE_W;
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    typedef enum logic {
        A_IDLE  = 1'b0,
        A_BURST = 1'b1
    } a_state_e;

    a_state_e         state_q, state_d;
    logic             grant_q, grant_d;
    logic             stall_q, stall_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
`ifndef TLARB_FIXED_PRIO_EN
    logic             rr_ptr_q, rr_ptr_d;
`endif

    logic                pick, grant, sel_valid, fire, msg_done, is_put;
    logic [2:0]          sel_opcode, sel_param;
    logic [SIZE_W-1:0]   sel_size, shamt;
    logic [SOURCE_W-1:0] sel_source;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W/8-1:0] sel_mask;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_corrupt;
    logic [CNT_W-1:0]    beats;
    logic                d_sel;

    // Grant is frozen during a burst and while a presented beat is stalled, so a
    // waiting request is never swapped for the other master's.
    always_comb begin
`ifdef TLARB_FIXED_PRIO_EN
        pick = !m0_a_valid && m1_a_valid;
`else
        pick = (m0_a_valid && m1_a_valid) ? rr_ptr_q : m1_a_valid;
`endif
        grant = (state_q == A_BURST || stall_q) ? grant_q : pick;
    end

    always_comb begin
        sel_valid   = grant ? m1_a_valid   : m0_a_valid;
        sel_opcode  = grant ? m1_a_opcode  : m0_a_opcode;
        sel_param   = grant ? m1_a_param   : m0_a_param;
        sel_size    = grant ? m1_a_size    : m0_a_size;
        sel_source  = grant ? m1_a_source  : m0_a_source;
        sel_address = grant ? m1_a_address : m0_a_address;
        sel_mask    = grant ? m1_a_mask    : m0_a_mask;
        sel_data    = grant ? m1_a_data    : m0_a_data;
        sel_corrupt = grant ? m1_a_corrupt : m0_a_corrupt;
    end

    // Puts span 2^size bytes over DATA_W/8-byte beats; anything else is one beat.
    always_comb begin
        is_put = (sel_opcode == OP_PUT_FULL) || (sel_opcode == OP_PUT_PARTIAL);
        shamt  = '0;
        if (sel_size > SIZE_W'(LANE_LOG2)) begin
            shamt = sel_size - SIZE_W'(LANE_LOG2);
        end
        beats = is_put ? (CNT_W'(1) << shamt) : CNT_W'(1);
    end

    assign fire = reset_n && sel_valid && s_a_ready;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant;
        stall_d     = reset_n && sel_valid && !s_a_ready;
        remaining_d = remaining_q;
        msg_done    = 1'b0;
        case (state_q)
            A_IDLE: begin
                if (fire) begin
                    if (beats > CNT_W'(1)) begin
                        state_d     = A_BURST;
                        remaining_d = beats - CNT_W'(1);
                    end else begin
                        msg_done = 1'b1;
                    end
                end
            end
            A_BURST: begin
                if (fire) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (remaining_q == CNT_W'(1)) begin
                        state_d  = A_IDLE;
                        msg_done = 1'b1;
                    end
                end
            end
            default: state_d = A_IDLE;
        endcase
`ifndef TLARB_FIXED_PRIO_EN
        rr_ptr_d = msg_done ? ~grant : rr_ptr_q;
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= A_IDLE;
            grant_q     <= 1'b0;
            stall_q     <= 1'b0;
            remaining_q <= '0;
`ifndef TLARB_FIXED_PRIO_EN
            rr_ptr_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            stall_q     <= stall_d;
            remaining_q <= remaining_d;
`ifndef TLARB_FIXED_PRIO_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    // Every output is held at zero while reset is asserted.
    always_comb begin
        s_a_valid   = 1'b0;
        m0_a_ready  = 1'b0;
        m1_a_ready  = 1'b0;
        s_a_opcode  = '0;
        s_a_param   = '0;
        s_a_size    = '0;
        s_a_source  = '0;
        s_a_address = '0;
        s_a_mask    = '0;
        s_a_data    = '0;
        s_a_corrupt = 1'b0;
        if (reset_n) begin
            s_a_valid   = sel_valid;
            m0_a_ready  = !grant && s_a_ready;
            m1_a_ready  = grant && s_a_ready;
            s_a_opcode  = sel_opcode;
            s_a_param   = sel_param;
            s_a_size    = sel_size;
            s_a_source  = {grant, sel_source};
            s_a_address = sel_address;
            s_a_mask    = sel_mask;
            s_a_data    = sel_data;
            s_a_corrupt = sel_corrupt;
        end
    end

    assign d_sel = s_d_source[SOURCE_W];

    always_comb begin
        m0_d_valid   = 1'b0;
        m1_d_valid   = 1'b0;
        s_d_ready    = 1'b0;
        m0_d_opcode  = '0;
        m0_d_param   = '0;
        m0_d_size    = '0;
        m0_d_source  = '0;
        m0_d_data    = '0;
        m0_d_denied  = 1'b0;
        m0_d_corrupt = 1'b0;
        m1_d_opcode  = '0;
        m1_d_param   = '0;
        m1_d_size    = '0;
        m1_d_source  = '0;
        m1_d_data    = '0;
        m1_d_denied  = 1'b0;
        m1_d_corrupt = 1'b0;
        if (reset_n) begin
            m0_d_valid   = s_d_valid && !d_sel;
            m1_d_valid   = s_d_valid && d_sel;
            s_d_ready    = d_sel ? m1_d_ready : m0_d_ready;
            m0_d_opcode  = s_d_opcode;
            m0_d_param   = s_d_param;
            m0_d_size    = s_d_size;
            m0_d_source  = s_d_source[SOURCE_W-1:0];
            m0_d_data    = s_d_data;
            m0_d_denied  = s_d_denied;
            m0_d_corrupt = s_d_corrupt;
            m1_d_opcode  = s_d_opcode;
            m1_d_param   = s_d_param;
            m1_d_size    = s_d_size;
            m1_d_source  = s_d_source[SOURCE_W-1:0];
            m1_d_data    = s_d_data;
            m1_d_denied  = s_d_denied;
            m1_d_corrupt = s_d_corrupt;
        end
    end

    assign dbg_a_state  = state_q;
    assign dbg_msg_done = msg_done;

`ifndef SYNTHESIS
    a_hold_stable: assert property (@(posedge clock) disable iff (!reset_n)
        (s_a_valid && !s_a_ready) |=> (s_a_valid && $stable({s_a_opcode, s_a_param, s_a_size,
            s_a_source, s_a_address, s_a_mask, s_a_data, s_a_corrupt})));
    no_get_burst: assert property (@(posedge clock) disable iff (!reset_n)
        (state_q == A_IDLE && state_d == A_BURST) |-> (s_a_opcode != OP_GET));
`endif

endmodule

// File: tb/tb_tl_ul_arbiter_2to1.sv
// Directed bench for tl_ul_arbiter_2to1: arbitration, burst locking, stalls, D routing, mid-burst reset.
module tb_tl_ul_arbiter_2to1;

    localparam int SOURCE_W = 3;
    localparam int SIZE_W   = 3;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;

    logic clock = 1'b0;
    logic reset_n;

    logic m0_a_valid, m0_a_ready, m0_a_corrupt;
    logic [2:0] m0_a_opcode, m0_a_param;
    logic [SIZE_W-1:0] m0_a_size;
    logic [SOURCE_W-1:0] m0_a_source;
    logic [ADDR_W-1:0] m0_a_address;
    logic [DATA_W/8-1:0] m0_a_mask;
    logic [DATA_W-1:0] m0_a_data;
    logic m0_d_valid, m0_d_ready, m0_d_denied, m0_d_corrupt;
    logic [2:0] m0_d_opcode;
    logic [1:0] m0_d_param;
    logic [SIZE_W-1:0] m0_d_size;
    logic [SOURCE_W-1:0] m0_d_source;
    logic [DATA_W-1:0] m0_d_data;

    logic m1_a_valid, m1_a_ready, m1_a_corrupt;
    logic [2:0] m1_a_opcode, m1_a_param;
    logic [SIZE_W-1:0] m1_a_size;
    logic [SOURCE_W-1:0] m1_a_source;
    logic [ADDR_W-1:0] m1_a_address;
    logic [DATA_W/8-1:0] m1_a_mask;
    logic [DATA_W-1:0] m1_a_data;
    logic m1_d_valid, m1_d_ready, m1_d_denied, m1_d_corrupt;
    logic [2:0] m1_d_opcode;
    logic [1:0] m1_d_param;
    logic [SIZE_W-1:0] m1_d_size;
    logic [SOURCE_W-1:0] m1_d_source;
    logic [DATA_W-1:0] m1_d_data;

    logic s_a_valid, s_a_ready, s_a_corrupt;
    logic [2:0] s_a_opcode, s_a_param;
    logic [SIZE_W-1:0] s_a_size;
    logic [SOURCE_W:0] s_a_source;
    logic [ADDR_W-1:0] s_a_address;
    logic [DATA_W/8-1:0] s_a_mask;
    logic [DATA_W-1:0] s_a_data;
    logic s_d_valid, s_d_ready, s_d_denied, s_d_corrupt;
    logic [2:0] s_d_opcode;
    logic [1:0] s_d_param;
    logic [SIZE_W-1:0] s_d_size;
    logic [SOURCE_W:0] s_d_source;
    logic [DATA_W-1:0] s_d_data;

    logic dbg_a_state, dbg_msg_done;

    int n_checks = 0;
    int n_fail   = 0;

    tl_ul_arbiter_2to1 #(
        .SOURCE_W(SOURCE_W), .SIZE_W(SIZE_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_a_valid(m0_a_valid), .m0_a_ready(m0_a_ready), .m0_a_opcode(m0_a_opcode),
        .m0_a_param(m0_a_param), .m0_a_size(m0_a_size), .m0_a_source(m0_a_source),
        .m0_a_address(m0_a_address), .m0_a_mask(m0_a_mask), .m0_a_data(m0_a_data),
        .m0_a_corrupt(m0_a_corrupt),
        .m0_d_valid(m0_d_valid), .m0_d_ready(m0_d_ready), .m0_d_opcode(m0_d_opcode),
        .m0_d_param(m0_d_param), .m0_d_size(m0_d_size), .m0_d_source(m0_d_source),
        .m0_d_data(m0_d_data), .m0_d_denied(m0_d_denied), .m0_d_corrupt(m0_d_corrupt),
        .m1_a_valid(m1_a_valid), .m1_a_ready(m1_a_ready), .m1_a_opcode(m1_a_opcode),
        .m1_a_param(m1_a_param), .m1_a_size(m1_a_size), .m1_a_source(m1_a_source),
        .m1_a_address(m1_a_address), .m1_a_mask(m1_a_mask), .m1_a_data(m1_a_data),
        .m1_a_corrupt(m1_a_corrupt),
        .m1_d_valid(m1_d_valid), .m1_d_ready(m1_d_ready), .m1_d_opcode(m1_d_opcode),
        .m1_d_param(m1_d_param), .m1_d_size(m1_d_size), .m1_d_source(m1_d_source),
        .m1_d_data(m1_d_data), .m1_d_denied(m1_d_denied), .m1_d_corrupt(m1_d_corrupt),
        .s_a_valid(s_a_valid), .s_a_ready(s_a_ready), .s_a_opcode(s_a_opcode),
        .s_a_param(s_a_param), .s_a_size(s_a_size), .s_a_source(s_a_source),
        .s_a_address(s_a_address), .s_a_mask(s_a_mask), .s_a_data(s_a_data),
        .s_a_corrupt(s_a_corrupt),
        .s_d_valid(s_d_valid), .s_d_ready(s_d_ready), .s_d_opcode(s_d_opcode),
        .s_d_param(s_d_param), .s_d_size(s_d_size), .s_d_source(s_d_source),
        .s_d_data(s_d_data), .s_d_denied(s_d_denied), .s_d_corrupt(s_d_corrupt),
        .dbg_a_state(dbg_a_state), .dbg_msg_done(dbg_msg_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic set_m0(input logic v, input logic [2:0] op, input logic [SIZE_W-1:0] sz,
                          input logic [SOURCE_W-1:0] src, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
        m0_a_valid = v; m0_a_opcode = op; m0_a_size = sz; m0_a_source = src;
        m0_a_address = addr; m0_a_data = data;
    endtask

    task automatic set_m1(input logic v, input logic [2:0] op, input logic [SIZE_W-1:0] sz,
                          input logic [SOURCE_W-1:0] src, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
        m1_a_valid = v; m1_a_opcode = op; m1_a_size = sz; m1_a_source = src;
        m1_a_address = addr; m1_a_data = data;
    endtask

    initial begin
        // Clock/reset and idle inputs; some valids are raised to prove reset gating.
        reset_n = 1'b0;
        set_m0(1'b1, 3'd4, 3'd2, 3'd5, 32'h100, 32'h0);
        set_m1(1'b0, 3'd4, 3'd2, 3'd2, 32'h200, 32'h0);
        m0_a_param = 3'd0; m0_a_mask = 4'hF; m0_a_corrupt = 1'b0;
        m1_a_param = 3'd0; m1_a_mask = 4'hF; m1_a_corrupt = 1'b0;
        m0_d_ready = 1'b1; m1_d_ready = 1'b0;
        s_a_ready = 1'b1;
        s_d_valid = 1'b1; s_d_opcode = 3'd1; s_d_param = 2'd0; s_d_size = 3'd2;
        s_d_source = 4'b0001; s_d_data = 32'h1234_5678; s_d_denied = 1'b0; s_d_corrupt = 1'b0;
        #3;
        check("rst_s_a_valid", s_a_valid, 0);
        check("rst_m0_a_ready", m0_a_ready, 0);
        check("rst_s_a_address", s_a_address, 0);
        check("rst_m0_d_valid", m0_d_valid, 0);
        check("rst_s_d_ready", s_d_ready, 0);
        check("rst_m0_d_data", m0_d_data, 0);
        check("rst_state", dbg_a_state, 0);
        tick();
        tick();
        s_d_valid = 1'b0;
        reset_n = 1'b1;

        // Both masters issue Get back to back.
        set_m1(1'b1, 3'd4, 3'd2, 3'd2, 32'h200, 32'h0);
        #1;
`ifdef TLARB_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) begin
            check("fixed_src", s_a_source, 4'h5);
            check("fixed_m1_starved", m1_a_ready, 0);
            tick();
        end
`else
        for (int i = 0; i < 2; i++) begin
            check("rr0_src", s_a_source, 4'h5);
            check("rr0_addr", s_a_address, 32'h100);
            check("rr0_m1_ready", m1_a_ready, 0);
            tick();
            check("rr1_src", s_a_source, 4'hA);
            check("rr1_addr", s_a_address, 32'h200);
            check("rr1_m0_ready", m0_a_ready, 0);
            tick();
        end
`endif

        // m0 PutFull size 4 = 4 beats while m1 keeps requesting.
        set_m0(1'b1, 3'd0, 3'd4, 3'd1, 32'h1000, 32'hA0);
        #1;
        check("b1_src", s_a_source, 4'h1);
        check("b1_m0_ready", m0_a_ready, 1);
        check("b1_m1_ready", m1_a_ready, 0);
        tick();
        for (int i = 1; i < 4; i++) begin
            m0_a_data = 32'hA0 + 32'(i);
            #1;
            check("burst_state", dbg_a_state, 1);
            check("burst_src", s_a_source, 4'h1);
            check("burst_data", s_a_data, 32'hA0 + 32'(i));
            check("burst_m1_ready", m1_a_ready, 0);
            tick();
        end
        m0_a_valid = 1'b0;
        #1;
        check("post_burst_state", dbg_a_state, 0);
        check("post_burst_src", s_a_source, 4'hA);
        check("post_burst_m1_ready", m1_a_ready, 1);
        tick();

        // m0 burst with a valid gap and a slave stall; m1 waits until beat 4 fires.
        set_m0(1'b1, 3'd0, 3'd4, 3'd1, 32'h2000, 32'hB0);
        #1;
        check("gap_b1_m0_ready", m0_a_ready, 1);
        tick();
        m0_a_valid = 1'b0;
        #1;
        check("gap_s_valid", s_a_valid, 0);
        check("gap_m1_ready", m1_a_ready, 0);
        tick();
        m0_a_valid = 1'b1; m0_a_data = 32'hB1;
        #1;
        check("gap_b2_data", s_a_data, 32'hB1);
        check("gap_b2_m1_ready", m1_a_ready, 0);
        tick();
        m0_a_data = 32'hB2; s_a_ready = 1'b0;
        #1;
        check("stall_m0_ready", m0_a_ready, 0);
        check("stall_s_valid", s_a_valid, 1);
        check("stall_m1_ready", m1_a_ready, 0);
        tick();
        s_a_ready = 1'b1;
        #1;
        check("stall_held_data", s_a_data, 32'hB2);
        check("stall_held_src", s_a_source, 4'h1);
        check("stall_m0_ready_back", m0_a_ready, 1);
        tick();
        m0_a_data = 32'hB3;
        #1;
        check("gap_b4_m1_ready", m1_a_ready, 0);
        check("gap_b4_data", s_a_data, 32'hB3);
        tick();
        m0_a_valid = 1'b0;
        #1;
        check("gap_after_src", s_a_source, 4'hA);
        check("gap_after_m1_ready", m1_a_ready, 1);
        tick();
        m1_a_valid = 1'b0;

        // D routing by source MSB.
        s_d_valid = 1'b1; s_d_source = 4'b1010; s_d_data = 32'hDEAD_BEEF;
        m0_d_ready = 1'b0; m1_d_ready = 1'b1;
        #1;
        check("d1_m1_valid", m1_d_valid, 1);
        check("d1_m1_source", m1_d_source, 3'b010);
        check("d1_m0_valid", m0_d_valid, 0);
        check("d1_s_ready", s_d_ready, 1);
        check("d1_m1_data", m1_d_data, 32'hDEAD_BEEF);
        m1_d_ready = 1'b0;
        #1;
        check("d1_s_ready_low", s_d_ready, 0);
        s_d_source = 4'b0011; m0_d_ready = 1'b1;
        #1;
        check("d0_m0_valid", m0_d_valid, 1);
        check("d0_m0_source", m0_d_source, 3'b011);
        check("d0_m1_valid", m1_d_valid, 0);
        check("d0_s_ready", s_d_ready, 1);
        s_d_valid = 1'b0;
        tick();

        // Reset in the middle of an m1 burst with two beats remaining.
        set_m0(1'b1, 3'd4, 3'd2, 3'd5, 32'h300, 32'h0);
        tick();
        m0_a_valid = 1'b0;
        set_m1(1'b1, 3'd0, 3'd4, 3'd3, 32'h4000, 32'hC0);
        #1;
        check("mr_b1_m1_ready", m1_a_ready, 1);
        tick();
        tick();
        s_d_valid = 1'b1; s_d_source = 4'b1010; m1_d_ready = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mr_s_valid", s_a_valid, 0);
        check("mr_m0_ready", m0_a_ready, 0);
        check("mr_m1_ready", m1_a_ready, 0);
        check("mr_m1_d_valid", m1_d_valid, 0);
        check("mr_s_d_ready", s_d_ready, 0);
        check("mr_s_data", s_a_data, 0);
        check("mr_state", dbg_a_state, 0);
        tick();
        tick();
        s_d_valid = 1'b0;
        set_m0(1'b1, 3'd4, 3'd2, 3'd5, 32'h500, 32'h0);
        set_m1(1'b1, 3'd4, 3'd2, 3'd6, 32'h600, 32'h0);
        reset_n = 1'b1;
        #1;
        check("rel_src", s_a_source, 4'h5);
        check("rel_m0_ready", m0_a_ready, 1);
        check("rel_m1_ready", m1_a_ready, 0);
        tick();
`ifdef TLARB_FIXED_PRIO_EN
        check("rel_next_src", s_a_source, 4'h5);
`else
        check("rel_next_src", s_a_source, 4'hE);
`endif
        tick();
        m0_a_valid = 1'b0; m1_a_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
